snn_batch_sequencer: RTL and testbench
======================================

# snn_batch_sequencer

Hardware batch-inference sequencer that drives a single `snn_fc_top`-style SNN core through `NUM_SAMPLES` consecutive samples. For each sample it issues a soft reset and a start pulse to the core, waits for `done` or a timeout, and stores the predicted class. It compares each prediction against a preloaded label and keeps running correct and timeout counts. It sits between a host or test controller and one shared inference core, replacing one-core-per-sample instantiation with time-multiplexed reuse, and generalises the class count beyond binary.

## Interface
Parameters:
- `NUM_SAMPLES`, 20, number of samples in a batch (≥1)
- `NUM_CLASSES`, 2, number of output classes (≥2); `CLASS_W = max(1, $clog2(NUM_CLASSES))`
- `TIMEOUT_CYCLES`, 65535, maximum WAIT cycles per sample (≥2); `TMR_W = $clog2(TIMEOUT_CYCLES+1)`
- `CORE_RST_CYCLES`, 2, length of the core soft-reset pulse (≥1)
- Derived: `IDX_W = max(1, $clog2(NUM_SAMPLES))`, `CNT_W = $clog2(NUM_SAMPLES+1)`

Ports:
- `clk`  in  1  single clock, all logic on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `batch_start`  in  1  begin a batch; accepted only in IDLE
- `abort`  in  1  synchronous abort of a running batch
- `lbl_we`  in  1  label write strobe; honoured only in IDLE
- `lbl_addr`  in  IDX_W  label index
- `lbl_data`  in  CLASS_W  expected class
- `core_rst`  out  1  soft reset to the core
- `core_start`  out  1  one-cycle start pulse to the core
- `core_sample_idx`  out  IDX_W  current sample index, selects the core's spike stream
- `core_done`  in  1  core completion (level or pulse)
- `core_class`  in  CLASS_W  core prediction, valid while `core_done` is high
- `rd_addr`  in  IDX_W  result readback index
- `rd_class`  out  CLASS_W  stored prediction, combinational read
- `rd_timeout`  out  1  sample timed out
- `rd_valid`  out  1  result written during the current or last batch
- `batch_busy`  out  1  high in every state except IDLE
- `batch_done`  out  1  one-cycle pulse on batch completion
- `aborted`  out  1  last batch ended by abort; cleared on `batch_start`
- `correct_count`  out  CNT_W  predictions equal to label
- `timeout_count`  out  CNT_W  samples that timed out

## Operation
- Outputs on reset: all outputs 0, `core_sample_idx` = 0, all `rd_valid` bits cleared. Label and class memories are not reset.
- FSM states: IDLE, CLR, START, WAIT, STORE, DONE.
- IDLE → CLR on `batch_start`.
  - Clears `idx`, both counters, all valid bits and `aborted`.
- CLR
  - `core_rst` = 1 for exactly `CORE_RST_CYCLES` cycles, then → START.
- START
  - `core_start` = 1 for one cycle.
  - Timer cleared, then → WAIT.
- WAIT
  - `core_done` is sampled from the first WAIT cycle onward; a `core_done` during CLR or START is ignored.
  - On `core_done`: capture `core_class`, set timeout flag = 0, → STORE.
  - On timer == `TIMEOUT_CYCLES-1` without `core_done`: capture class 0, set timeout flag = 1, → STORE.
  - If `core_done` arrives in the timeout cycle, `core_done` wins.
- STORE
  - Write class, timeout flag and valid = 1 at `idx`.
  - If not timed out and class == label[idx]: `correct_count`++.
  - If timed out: `timeout_count`++.
  - Out-of-range classes (≥ `NUM_CLASSES`) are compared literally.
  - If `idx == NUM_SAMPLES-1` → DONE; otherwise `idx`++ → CLR.
- DONE
  - `batch_done` = 1 for one cycle, then → IDLE.
- `core_sample_idx` = `idx` at all times.
- `abort` in any state other than IDLE and DONE:
  - Next state is IDLE, `core_rst` = 1 in that abort cycle, `aborted` = 1.
  - No `batch_done` pulse; counters and stored results keep their partial values.
  - A STORE in the abort cycle is suppressed.
- `batch_start` outside IDLE, `lbl_we` outside IDLE, and `abort` in IDLE are all ignored.
- Asynchronous reset mid-batch returns to IDLE with reset values immediately.

## Timing
- Per-sample latency, from CLR entry to the next CLR or DONE: `CORE_RST_CYCLES` + 1 (START) + k + 1 (STORE) cycles.
  - k = WAIT cycles up to and including the one where `core_done` is sampled, 1 ≤ k ≤ `TIMEOUT_CYCLES`.
- `batch_start` in cycle t: `core_rst` high in cycles t+1 … t+`CORE_RST_CYCLES`; `core_start` high in cycle t+`CORE_RST_CYCLES`+1.
- Counters and memory update on the rising edge that ends STORE; visible on `rd_*` the next cycle.
- `batch_done` fires the cycle after the last STORE. `batch_busy` falls in the cycle after `batch_done`.
- Counters never wrap; the maximum value is `NUM_SAMPLES`.

## Test plan
- NUM_SAMPLES=4, NUM_CLASSES=2, labels {0,1,1,0}, core model answers {0,1,0,0} after 10 cycles → `correct_count`=3, `timeout_count`=0, one `batch_done` pulse; per-sample latency 2+1+10+1=14 cycles.
- NUM_CLASSES=5, labels {4,2,3}, core answers {4,2,1} → `rd_class` {4,2,1}, `correct_count`=2.
- TIMEOUT_CYCLES=8, core silent on sample 1 → sample 1 stored with `rd_timeout`=1, class 0; `timeout_count`=1; WAIT lasts exactly 8 cycles.
- `core_done` held high from CLR onward → not sampled before WAIT; class captured in the first WAIT cycle.
- `abort` asserted in WAIT of sample 2 → IDLE next cycle, `core_rst` pulse, `aborted`=1, no `batch_done`, `rd_valid`=1 only for samples 0–1.
- `rst` asserted mid-WAIT, then `batch_start` with `lbl_we` attempted while busy → outputs at reset values; label write ignored; new batch runs cleanly from `idx` 0.

Source files
------------

// File: rtl/snn_batch_sequencer_if.sv
// Connection between the batch sequencer and one shared SNN inference core.
// The sequencer drives reset/start/sample index; the core returns done and its class.
interface snn_batch_sequencer_if #(
    parameter int IDX_W   = 5,
    parameter int CLASS_W = 1
);
    logic               core_rst;
    logic               core_start;
    logic [IDX_W-1:0]   core_sample_idx;
    logic               core_done;
    logic [CLASS_W-1:0] core_class;

    modport master (
        output core_rst,
        output core_start,
        output core_sample_idx,
        input  core_done,
        input  core_class
    );

    modport slave (
        input  core_rst,
        input  core_start,
        input  core_sample_idx,
        output core_done,
        output core_class
    );
endinterface

// File: rtl/snn_batch_sequencer.sv
// Runs a batch of samples through one shared SNN core: soft reset, start, wait
// for done or timeout, store the prediction and score it against preloaded labels.
module snn_batch_sequencer #(
    parameter int NUM_SAMPLES     = 20,
    parameter int NUM_CLASSES     = 2,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int CORE_RST_CYCLES = 2,
    localparam int CLASS_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
    localparam int IDX_W   = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    localparam int CNT_W   = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                batch_start,
    input  logic                abort,
    input  logic                lbl_we,
    input  logic [IDX_W-1:0]    lbl_addr,
    input  logic [CLASS_W-1:0]  lbl_data,
    snn_batch_sequencer_if.master core,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [CLASS_W-1:0]  rd_class,
    output logic                rd_timeout,
    output logic                rd_valid,
    output logic                batch_busy,
    output logic                batch_done,
    output logic                aborted,
    output logic [CNT_W-1:0]    correct_count,
    output logic [CNT_W-1:0]    timeout_count
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RST_W = $clog2(CORE_RST_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE, CLR, START, WAIT, STORE, DONE
    } state_t;

    state_t             state, state_nx;
    logic [IDX_W-1:0]   idx;
    logic [RST_W-1:0]   rst_cnt;
    logic [TMR_W-1:0]   tmr;
    logic [CLASS_W-1:0] cap_class;
    logic               cap_to;
    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   to_mem;
    logic [CLASS_W-1:0] class_mem [DEPTH];
    logic [CLASS_W-1:0] lbl_mem   [DEPTH];
    logic               aborted_q;
    logic [CNT_W-1:0]   correct_q;
    logic [CNT_W-1:0]   timeout_q;

    logic batch_go;
    logic do_abort;
    logic do_capture;
    logic cap_to_nx;
    logic do_store;

    always_comb begin
        state_nx   = state;
        batch_go   = 1'b0;
        do_abort   = 1'b0;
        do_capture = 1'b0;
        cap_to_nx  = 1'b0;
        do_store   = 1'b0;
        case (state)
            IDLE: begin
                if (batch_start) begin
                    batch_go = 1'b1;
                    state_nx = CLR;
                end
            end
            CLR: begin
                if (rst_cnt == RST_W'(CORE_RST_CYCLES - 1)) state_nx = START;
            end
            START: state_nx = WAIT;
            WAIT: begin
                // A done in the final timer cycle still counts as a real answer.
                if (core.core_done) begin
                    do_capture = 1'b1;
                    state_nx   = STORE;
                end else if (tmr == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    do_capture = 1'b1;
                    cap_to_nx  = 1'b1;
                    state_nx   = STORE;
                end
            end
            STORE: begin
                do_store = 1'b1;
                state_nx = (idx == IDX_W'(NUM_SAMPLES - 1)) ? DONE : CLR;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE) begin
            do_abort   = 1'b1;
            do_capture = 1'b0;
            do_store   = 1'b0;
            state_nx   = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            rst_cnt   <= '0;
            tmr       <= '0;
            valid_q   <= '0;
            aborted_q <= 1'b0;
            correct_q <= '0;
            timeout_q <= '0;
        end else begin
            state   <= state_nx;
            rst_cnt <= (state == CLR) ? rst_cnt + 1'b1 : '0;
            tmr     <= (state == WAIT) ? tmr + 1'b1 : '0;
            if (batch_go) begin
                idx       <= '0;
                valid_q   <= '0;
                aborted_q <= 1'b0;
                correct_q <= '0;
                timeout_q <= '0;
            end
            if (do_abort) aborted_q <= 1'b1;
            if (do_store) begin
                valid_q[idx] <= 1'b1;
                if (cap_to) timeout_q <= timeout_q + 1'b1;
                else if (cap_class == lbl_mem[idx]) correct_q <= correct_q + 1'b1;
                if (state_nx == CLR) idx <= idx + 1'b1;
            end
        end
    end

    // Result and label storage is deliberately left unreset; rd_valid qualifies it.
    always_ff @(posedge clk) begin
        if (do_capture) begin
            cap_class <= cap_to_nx ? '0 : core.core_class;
            cap_to    <= cap_to_nx;
        end
        if (lbl_we && state == IDLE) lbl_mem[lbl_addr] <= lbl_data;
        if (do_store) begin
            class_mem[idx] <= cap_class;
            to_mem[idx]    <= cap_to;
        end
    end

    assign core.core_rst        = (state == CLR) || do_abort;
    assign core.core_start      = (state == START);
    assign core.core_sample_idx = idx;

    assign rd_class      = class_mem[rd_addr];
    assign rd_timeout    = to_mem[rd_addr];
    assign rd_valid      = valid_q[rd_addr];
    assign batch_busy    = (state != IDLE);
    assign batch_done    = (state == DONE);
    assign aborted       = aborted_q;
    assign correct_count = correct_q;
    assign timeout_count = timeout_q;
endmodule

// File: tb/tb_snn_batch_sequencer.sv
// Bench for snn_batch_sequencer: table vectors, directed corner sequences and
// randomized batches scored by a per-sample reference model.
module tb_snn_batch_sequencer;
    localparam int N       = 4;
    localparam int NC      = 5;
    localparam int T       = 12;
    localparam int R       = 2;
    localparam int IDX_W   = 2;
    localparam int CLASS_W = 3;
    localparam int CNT_W   = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               batch_start;
    logic               abort;
    logic               lbl_we;
    logic [IDX_W-1:0]   lbl_addr;
    logic [CLASS_W-1:0] lbl_data;
    logic [IDX_W-1:0]   rd_addr;
    logic [CLASS_W-1:0] rd_class;
    logic               rd_timeout;
    logic               rd_valid;
    logic               batch_busy;
    logic               batch_done;
    logic               aborted;
    logic [CNT_W-1:0]   correct_count;
    logic [CNT_W-1:0]   timeout_count;

    snn_batch_sequencer_if #(.IDX_W(IDX_W), .CLASS_W(CLASS_W)) core ();

    snn_batch_sequencer #(
        .NUM_SAMPLES(N), .NUM_CLASSES(NC), .TIMEOUT_CYCLES(T), .CORE_RST_CYCLES(R)
    ) dut (
        .clk(clk), .rst(rst), .batch_start(batch_start), .abort(abort),
        .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_data(lbl_data), .core(core),
        .rd_addr(rd_addr), .rd_class(rd_class), .rd_timeout(rd_timeout),
        .rd_valid(rd_valid), .batch_busy(batch_busy), .batch_done(batch_done),
        .aborted(aborted), .correct_count(correct_count), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] lbl;     // {s3,s2,s1,s0}
        logic [11:0] cls;
        logic [31:0] k;
        logic [3:0]  silent;
        logic [7:0]  exp_correct;
        logic [7:0]  exp_timeout;
        logic [15:0] exp_cycles;
    } vec_t;

    int  checks = 0;
    int  errors = 0;
    int  m_lbl [N];
    int  m_cls [N];
    int  m_k   [N];
    bit  m_sil [N];
    bit  hold_mode = 1'b0;
    bit  armed = 1'b0;
    int  wn = 0;

    // Core stand-in: answers in the k-th cycle after its start pulse, or never.
    always @(negedge clk) begin
        if (hold_mode) begin
            armed = 1'b0;
            core.core_done  = 1'b1;
            core.core_class = 3'(m_cls[int'(core.core_sample_idx)]);
        end else if (rst || core.core_rst) begin
            armed = 1'b0;
            wn = 0;
            core.core_done  = 1'b0;
            core.core_class = '0;
        end else if (core.core_start) begin
            armed = 1'b1;
            wn = 0;
            core.core_done = 1'b0;
        end else if (armed) begin
            wn++;
            if (wn == m_k[int'(core.core_sample_idx)] && !m_sil[int'(core.core_sample_idx)]) begin
                core.core_done  = 1'b1;
                core.core_class = 3'(m_cls[int'(core.core_sample_idx)]);
            end else begin
                core.core_done = 1'b0;
            end
        end else begin
            core.core_done = 1'b0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic bit ref_to(input int s);
        if (hold_mode) return 1'b0;
        return m_sil[s] || (m_k[s] > T);
    endfunction

    function automatic int ref_cls(input int s);
        return ref_to(s) ? 0 : m_cls[s];
    endfunction

    function automatic int ref_k(input int s);
        if (hold_mode) return 1;
        return ref_to(s) ? T : m_k[s];
    endfunction

    function automatic int ref_correct();
        int c = 0;
        for (int s = 0; s < N; s++) if (!ref_to(s) && ref_cls(s) == m_lbl[s]) c++;
        return c;
    endfunction

    function automatic int ref_timeouts();
        int c = 0;
        for (int s = 0; s < N; s++) if (ref_to(s)) c++;
        return c;
    endfunction

    function automatic int ref_cycles();
        int c = 1;
        for (int s = 0; s < N; s++) c += R + 1 + ref_k(s) + 1;
        return c;
    endfunction

    task automatic write_labels();
        for (int s = 0; s < N; s++) begin
            @(negedge clk);
            lbl_we = 1'b1; lbl_addr = 2'(s); lbl_data = 3'(m_lbl[s]);
        end
        @(negedge clk);
        lbl_we = 1'b0;
    endtask

    task automatic wait_start_idx(input int s, input string nm);
        int c = 0;
        bit seen = 1'b0;
        while (!seen && c < 500) begin
            @(negedge clk); c++;
            if (core.core_start && int'(core.core_sample_idx) == s) seen = 1'b1;
        end
        check({nm, "_start_seen"}, int'(seen), 1);
    endtask

    // poke > 0 attempts batch_start and a label write in that cycle of the run.
    task automatic run_batch(input string nm, input int poke, input int exp_cyc);
        int c = 0, cyc = -1, ndone = 0, first_rst = -1, rst_len = 0, first_start = -1;
        bit fin = 1'b0;
        @(negedge clk);
        batch_start = 1'b1;
        @(posedge clk);
        #1 batch_start = 1'b0;
        while (!fin && c < 3000) begin
            @(negedge clk); c++;
            if (c == poke) begin
                batch_start = 1'b1; lbl_we = 1'b1; lbl_addr = 2'd3; lbl_data = 3'd0;
            end else if (poke > 0 && c == poke + 1) begin
                batch_start = 1'b0; lbl_we = 1'b0;
            end
            if (first_start < 0 && core.core_rst) begin
                if (first_rst < 0) first_rst = c;
                rst_len++;
            end
            if (first_start < 0 && core.core_start) first_start = c;
            if (batch_done) begin ndone++; cyc = c; end
            if (!batch_busy) fin = 1'b1;
        end
        check({nm, "_finished"}, int'(fin), 1);
        check({nm, "_cycles"}, cyc, exp_cyc);
        check({nm, "_done_pulses"}, ndone, 1);
        check({nm, "_busy_fall"}, c, cyc + 1);
        check({nm, "_core_rst_first"}, first_rst, 1);
        check({nm, "_core_rst_len"}, rst_len, R);
        check({nm, "_core_start_cycle"}, first_start, R + 1);
    endtask

    task automatic check_results(input string nm, input int exp_c, input int exp_t);
        check({nm, "_correct"}, int'(correct_count), exp_c);
        check({nm, "_timeouts"}, int'(timeout_count), exp_t);
        check({nm, "_aborted"}, int'(aborted), 0);
        for (int s = 0; s < N; s++) begin
            rd_addr = 2'(s);
            #1;
            check($sformatf("%s_valid%0d", nm, s), int'(rd_valid), 1);
            check($sformatf("%s_class%0d", nm, s), int'(rd_class), ref_cls(s));
            check($sformatf("%s_to%0d", nm, s), int'(rd_timeout), int'(ref_to(s)));
        end
    endtask

    vec_t vecs [5];

    initial begin
        vecs[0] = '{ {3'd0,3'd1,3'd1,3'd0}, {3'd0,3'd0,3'd1,3'd0}, {8'd10,8'd10,8'd10,8'd10},
                     4'b0000, 8'd3, 8'd0, 16'd57 };
        vecs[1] = '{ {3'd0,3'd3,3'd2,3'd4}, {3'd0,3'd1,3'd2,3'd4}, {8'd1,8'd7,8'd5,8'd3},
                     4'b0000, 8'd3, 8'd0, 16'd33 };
        vecs[2] = '{ {3'd3,3'd2,3'd0,3'd1}, {3'd3,3'd2,3'd5,3'd1}, {8'd4,8'd12,8'd1,8'd2},
                     4'b0010, 8'd3, 8'd1, 16'd47 };
        vecs[3] = '{ {3'd0,3'd6,3'd5,3'd7}, {3'd1,3'd6,3'd6,3'd7}, {8'd4,8'd3,8'd2,8'd1},
                     4'b0000, 8'd2, 8'd0, 16'd27 };
        vecs[4] = '{ {3'd0,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd0,3'd0}, {8'd1,8'd1,8'd1,8'd13},
                     4'b0000, 8'd3, 8'd1, 16'd32 };

        rst = 1'b1; batch_start = 1'b0; abort = 1'b0; lbl_we = 1'b0;
        lbl_addr = '0; lbl_data = '0; rd_addr = '0;
        for (int s = 0; s < N; s++) begin m_lbl[s] = 0; m_cls[s] = 0; m_k[s] = 1; m_sil[s] = 0; end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_core_rst", int'(core.core_rst), 0);
        check("rst_core_start", int'(core.core_start), 0);
        check("rst_sample_idx", int'(core.core_sample_idx), 0);
        check("rst_busy", int'(batch_busy), 0);
        check("rst_done", int'(batch_done), 0);
        check("rst_aborted", int'(aborted), 0);
        check("rst_correct", int'(correct_count), 0);
        check("rst_timeouts", int'(timeout_count), 0);
        for (int s = 0; s < N; s++) begin
            rd_addr = 2'(s);
            #1 check($sformatf("rst_valid%0d", s), int'(rd_valid), 0);
        end

        for (int v = 0; v < 5; v++) begin
            for (int s = 0; s < N; s++) begin
                m_lbl[s] = int'(vecs[v].lbl[3*s +: 3]);
                m_cls[s] = int'(vecs[v].cls[3*s +: 3]);
                m_k[s]   = int'(vecs[v].k[8*s +: 8]);
                m_sil[s] = vecs[v].silent[s];
            end
            write_labels();
            run_batch($sformatf("vec%0d", v), 0, int'(vecs[v].exp_cycles));
            check_results($sformatf("vec%0d", v), int'(vecs[v].exp_correct),
                          int'(vecs[v].exp_timeout));
        end

        // core_done held high from before CLR: each sample resolves in its first WAIT cycle
        m_lbl = '{2, 1, 4, 3};
        m_cls = '{2, 0, 4, 3};
        write_labels();
        hold_mode = 1'b1;
        run_batch("hold", 0, 1 + N * (R + 3));
        check_results("hold", 3, 0);
        @(negedge clk);
        hold_mode = 1'b0;

        // Abort during WAIT of sample 2
        m_lbl = '{0, 1, 1, 0};
        m_cls = '{0, 1, 1, 0};
        m_k   = '{10, 10, 10, 10};
        m_sil = '{0, 0, 0, 0};
        write_labels();
        @(negedge clk);
        batch_start = 1'b1;
        @(posedge clk);
        #1 batch_start = 1'b0;
        wait_start_idx(2, "abort");
        repeat (2) @(negedge clk);
        abort = 1'b1;
        #1 check("abort_core_rst", int'(core.core_rst), 1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(batch_busy), 0);
        check("abort_flag", int'(aborted), 1);
        check("abort_done", int'(batch_done), 0);
        check("abort_correct", int'(correct_count), 2);
        check("abort_timeouts", int'(timeout_count), 0);
        for (int s = 0; s < N; s++) begin
            rd_addr = 2'(s);
            #1 check($sformatf("abort_valid%0d", s), int'(rd_valid), (s < 2) ? 1 : 0);
        end
        begin
            int late_done = 0;
            repeat (20) begin
                @(negedge clk);
                if (batch_done) late_done++;
            end
            check("abort_no_done", late_done, 0);
        end
        abort = 1'b1;
        #1 check("idle_abort_core_rst", int'(core.core_rst), 0);
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", int'(batch_busy), 0);

        // Next batch clears aborted and rescoring starts from zero
        run_batch("post_abort", 0, 1 + N * (R + 12));
        check_results("post_abort", 4, 0);

        // Asynchronous reset in WAIT of sample 1, then a clean batch with busy-time pokes
        m_lbl = '{1, 2, 3, 4};
        m_cls = '{1, 2, 3, 4};
        m_k   = '{3, 3, 3, 3};
        write_labels();
        @(negedge clk);
        batch_start = 1'b1;
        @(posedge clk);
        #1 batch_start = 1'b0;
        wait_start_idx(1, "arst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        rd_addr = 2'd0;
        #1;
        check("arst_busy", int'(batch_busy), 0);
        check("arst_core_rst", int'(core.core_rst), 0);
        check("arst_core_start", int'(core.core_start), 0);
        check("arst_sample_idx", int'(core.core_sample_idx), 0);
        check("arst_correct", int'(correct_count), 0);
        check("arst_valid0", int'(rd_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        run_batch("arst_rerun", 5, 1 + N * (R + 5));
        check_results("arst_rerun", 4, 0);

        // Randomized batches against the model
        for (int it = 0; it < 8; it++) begin
            for (int s = 0; s < N; s++) begin
                m_lbl[s] = int'($urandom_range(0, NC - 1));
                m_cls[s] = ($urandom_range(0, 1) == 1) ? m_lbl[s] : int'($urandom_range(0, 7));
                m_k[s]   = int'($urandom_range(1, T + 2));
                m_sil[s] = ($urandom_range(0, 4) == 0);
            end
            write_labels();
            run_batch($sformatf("rand%0d", it), 0, ref_cycles());
            check_results($sformatf("rand%0d", it), ref_correct(), ref_timeouts());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
